rel_compare_pipe: RTL
=====================

// Module: rel_compare_pipe
// PURPOSE
//  Parametrised, pipelined relational-compare unit. Each beat carries A, B, an opcode
//  (LT/LE/GT/GE/EQ/NE) and a signed-mode bit; it returns the 1-bit result widened to OW.
//  Widening follows IEEE 1800 rules for mixed-width and mixed-sign operands.
//  Also keeps per-group ALL/ANY reductions, with groups delimited by in_last.
//  Sits behind operand staging in the compare/vector datapath; ready/valid on both sides.
// PARAMETERS
//  AW   9   width of operand A (>=1)
//  BW   6   width of operand B (>=1)
//  OW   16  width of out_res; the 1-bit result is zero-extended into it (>=1)
//  LAT  2   pipeline stages from accept to out_valid (>=1)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    beat offered
//  in_ready   out  1    beat accepted when in_valid & in_ready
//  in_op      in   3    rel_op_e: LT=0 LE=1 GT=2 GE=3 EQ=4 NE=5; 6,7 reserved
//  in_signed  in   1    1 = treat both operands as two's complement
//  in_a       in   AW   operand A
//  in_b       in   BW   operand B
//  in_last    in   1    final beat of a reduction group
//  out_valid  out  1    result beat present
//  out_ready  in   1    result consumed when out_valid & out_ready
//  out_res    out  OW   {(OW-1)'b0, cmp}
//  out_last   out  1    in_last, carried alongside the beat
//  out_all    out  1    AND of cmp over the group; meaningful only when out_last
//  out_any    out  1    OR of cmp over the group; meaningful only when out_last
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - every stage-valid = 0; out_res/out_last/out_all/out_any = 0
//   - accumulators: all_acc = 1, any_acc = 0
//   - a beat in flight at reset is dropped; no partial group survives reset
//  Width rule:
//   - compare width CW = max(AW,BW)
//   - in_signed=1: both operands sign-extended to CW, compared signed
//   - in_signed=0: both zero-extended, compared unsigned
//   - reserved opcode: cmp = 0, beat still flows
//  Pipeline:
//   - compute in stage 0 (registered on accept); stages 1..LAT-1 are plain registers
//   - stage k advances when it is empty or stage k+1 advances; last stage advances on out_ready
//   - in_ready = !v[0] | adv[0], combinational from out_ready (no bubble at full throughput)
//   - beats emerge exactly LAT cycles after accept when out_ready is held high
//   - stall: out_valid asserted with out_ready low holds all out_* stable (no change while stalled)
//   - beats are never reordered, duplicated or dropped
//  Reductions (updated at the output handshake only):
//   - all_acc &= cmp, any_acc |= cmp
//   - out_all/out_any present the value including the current beat
//   - on an out_last handshake, accumulators reload to 1/0 for the next group
//   - single-beat group: out_all = out_any = cmp
// STRUCTURE
//  Package rel_compare_pkg:
//   - typedef enum logic [2:0] rel_op_e
//   - function rel_eval(op, lt, eq) -> logic
//  Sub-module rel_compare_core:
//   - combinational; params AW, BW
//   - does extension and compare; outputs lt, eq
//  Top level holds the LAT-deep valid/ready register chain and the accumulators.
// TESTING
//  1. AW=9 BW=6, A=9'h1FF B=6'h3F, op=LE, signed=0 -> out_res=16'h0000 (511<=63 false)
//  2. Same operands, signed=1 -> out_res=16'h0001 (-1<=-1)
//  3. A=9'h0FF B=6'h20 signed=1, ops LT,GT,EQ,NE in 4 back-to-back beats, out_ready=1
//     -> results 0,1,0,1 on cycles LAT..LAT+3
//  4. 3-beat group, cmp=1,0,1; out_ready low for 3 cycles mid-stream
//     -> out_* frozen during stall; on out_last: out_all=0, out_any=1; next group starts all=1
//  5. rst_n pulsed low mid-group with 2 beats in flight -> out_valid=0 immediately;
//     first post-reset single-beat group with cmp=0 -> out_all=0, out_any=0
//  6. in_op=3'd7 -> out_res=0, out_valid still asserted after LAT cycles

Source files
------------

// File: rtl/rel_compare_pkg.sv
// Shared types and helpers for the pipelined relational-compare unit.
//   rel_op_e  : opcode encoding carried on in_op (codes 6 and 7 are reserved)
//   rel_beat_t: payload held in each pipeline stage
//   rel_eval  : turns core lt/eq flags into the opcode's 1-bit result
package rel_compare_pkg;

  typedef enum logic [2:0] {
    OP_LT = 3'd0,
    OP_LE = 3'd1,
    OP_GT = 3'd2,
    OP_GE = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } rel_op_e;

  typedef struct packed {
    logic last;
    logic cmp;
  } rel_beat_t;

  // Reserved codes fall through to 0 so the beat still flows with a defined result.
  function automatic logic rel_eval(input logic [2:0] op, input logic lt, input logic eq);
    logic r;
    r = 1'b0;
    case (op)
      OP_LT:   r = lt;
      OP_LE:   r = lt | eq;
      OP_GT:   r = ~lt & ~eq;
      OP_GE:   r = ~lt;
      OP_EQ:   r = eq;
      OP_NE:   r = ~eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rel_compare_core.sv
// Combinational operand extension and magnitude compare.
//   a, b : operands of width AW, BW
//   sgn  : 1 = both operands are two's complement
//   lt   : a < b at the common compare width
//   eq   : a == b at the common compare width
module rel_compare_core #(
  parameter int unsigned AW = 9,
  parameter int unsigned BW = 6
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  input  logic          sgn,
  output logic          lt,
  output logic          eq
);

  localparam int unsigned CW = (AW > BW) ? AW : BW;

  // One guard bit above CW lets a single signed compare serve both modes:
  // the guard is the sign in signed mode and 0 (pure magnitude) otherwise.
  logic signed [AW:0] a_s;
  logic signed [BW:0] b_s;
  logic signed [CW:0] a_x;
  logic signed [CW:0] b_x;

  assign a_s = {sgn & a[AW-1], a};
  assign b_s = {sgn & b[BW-1], b};
  assign a_x = (CW+1)'(a_s);
  assign b_x = (CW+1)'(b_s);

  assign lt = (a_x < b_x);
  assign eq = (a_x == b_x);

endmodule

// File: rtl/rel_compare_pipe.sv
// Pipelined relational-compare unit with per-group ALL/ANY reductions.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input handshake (in_ready combinational from out_ready)
//   in_op, in_signed    : opcode and signed-mode select
//   in_a, in_b, in_last : operands and group delimiter
//   out_valid/out_ready : output handshake
//   out_res             : compare result zero-extended to OW
//   out_last            : in_last carried with the beat
//   out_all, out_any    : group AND/OR including the current beat
module rel_compare_pipe
  import rel_compare_pkg::*;
#(
  parameter int unsigned AW  = 9,
  parameter int unsigned BW  = 6,
  parameter int unsigned OW  = 16,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic          in_signed,
  input  logic [AW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_res,
  output logic          out_last,
  output logic          out_all,
  output logic          out_any
);

  logic            cmp_lt;
  logic            cmp_eq;
  logic            cmp_c;
  logic [LAT-1:0]  v;
  logic [LAT-1:0]  adv;
  rel_beat_t       beat_q [LAT];
  logic            all_acc;
  logic            any_acc;
  logic            out_hs;

  rel_compare_core #(.AW(AW), .BW(BW)) u_core (
    .a   (in_a),
    .b   (in_b),
    .sgn (in_signed),
    .lt  (cmp_lt),
    .eq  (cmp_eq)
  );

  assign cmp_c = rel_eval(in_op, cmp_lt, cmp_eq);

  // Stage k may advance if out_ready is high or any stage at or after k is empty.
  always_comb begin
    logic [LAT-1:0] nv;
    adv = '0;
    nv  = ~v;
    for (int k = 0; k < LAT; k++) begin
      adv[k] = out_ready | (|(nv >> k));
    end
  end

  assign in_ready = adv[0];

  // Valid/payload chain: stage 0 captures the compare, later stages just shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < LAT; k++) begin
        beat_q[k] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          beat_q[0].cmp  <= cmp_c;
          beat_q[0].last <= in_last;
        end
      end
      for (int k = 1; k < LAT; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            beat_q[k] <= beat_q[k-1];
          end
        end
      end
    end
  end

  assign out_hs = out_valid & out_ready;

  // Group accumulators fold in each beat at the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_acc <= 1'b1;
      any_acc <= 1'b0;
    end else if (out_hs) begin
      if (beat_q[LAT-1].last) begin
        all_acc <= 1'b1;
        any_acc <= 1'b0;
      end else begin
        all_acc <= all_acc & beat_q[LAT-1].cmp;
        any_acc <= any_acc | beat_q[LAT-1].cmp;
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_res   = OW'(beat_q[LAT-1].cmp);
  assign out_last  = beat_q[LAT-1].last;
  assign out_all   = all_acc & beat_q[LAT-1].cmp;
  assign out_any   = any_acc | beat_q[LAT-1].cmp;

endmodule
